// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: pipeline control in, instruction memory handshake,
// and the IF/ID register contents presented to the decode stage.
interface instruction_fetch_unit_if;
  // pipeline control
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  // instruction memory handshake
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] imem_address;
  logic        imem_read;
  // IF/ID register and decoded fields
  logic [31:0] pc_if_id;
  logic [31:0] pc_plus4_if_id;
  logic [31:0] instruction_if_id;
  logic        valid_if_id;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        fetch_busy;

  // the fetch unit itself
  modport slave (
    input  stall, branch_taken, branch_target, imem_readdata, imem_busywait,
    output imem_address, imem_read, pc_if_id, pc_plus4_if_id,
           instruction_if_id, valid_if_id, opcode, func3, func7, fetch_busy
  );

  // the surrounding pipeline / memory
  modport master (
    output stall, branch_taken, branch_target, imem_readdata, imem_busywait,
    input  imem_address, imem_read, pc_if_id, pc_plus4_if_id,
           instruction_if_id, valid_if_id, opcode, func3, func7, fetch_busy
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage plus IF/ID pipeline register. Owns the PC, fetches over a
// READ/BUSYWAIT handshake, follows redirects from EX and holds on stalls.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_FETCH   | request outstanding at PC; completes when busywait is low
// S_DISCARD | redirected mid-fetch; drain abandoned request, then jump
// S_HOLD    | fetched word parked in hold buffer while decode is stalled
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  instruction_fetch_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_q, valid_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Redirect targets are always word aligned; the low bits are dropped.
  assign target   = bus.branch_target & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;

  // State and IF/ID register update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      redirect_q   <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc_id_q      <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pc_id_q      <= pc_id_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state and IF/ID next-value logic; branch beats stall everywhere
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    pc_id_d      = pc_id_q;
    valid_d      = valid_q;

    case (state_q)
      S_FETCH: begin
        if (!bus.imem_busywait) begin
          if (bus.branch_taken) begin
            pc_d    = target;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end else if (bus.stall) begin
            // Decode can't take the word yet: park it so it is neither
            // refetched nor lost, and move the PC past it.
            hold_instr_d = bus.imem_readdata;
            hold_pc_d    = pc_q;
            pc_d         = pc_plus4;
            state_d      = S_HOLD;
          end else begin
            instr_d = bus.imem_readdata;
            pc_id_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end else begin
          if (bus.branch_taken) begin
            // The request at pc_q must run to completion before the
            // address may change, so remember where to go afterwards.
            redirect_d = target;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
            state_d    = S_DISCARD;
          end else if (!bus.stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
      end

      S_DISCARD: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (bus.branch_taken) begin
          redirect_d = target;
        end
        if (!bus.imem_busywait) begin
          pc_d    = bus.branch_taken ? target : redirect_q;
          state_d = S_FETCH;
        end
      end

      S_HOLD: begin
        if (bus.branch_taken) begin
          pc_d         = target;
          instr_d      = NOP_INSTR;
          valid_d      = 1'b0;
          hold_instr_d = 32'h0;
          hold_pc_d    = 32'h0;
          state_d      = S_FETCH;
        end else if (!bus.stall) begin
          instr_d = hold_instr_q;
          pc_id_d = hold_pc_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // pc_q stays on the outstanding request address throughout DISCARD,
  // so the fetch address is pc_q in every requesting state.
  assign bus.imem_address      = pc_q;
  assign bus.imem_read         = (state_q != S_HOLD) && !rst_i;
  assign bus.fetch_busy        = (state_q != S_HOLD) && bus.imem_busywait;

  assign bus.pc_if_id          = pc_id_q;
  assign bus.pc_plus4_if_id    = pc_id_q + 32'd4;
  assign bus.instruction_if_id = instr_q;
  assign bus.valid_if_id       = valid_q;
  assign bus.opcode            = instr_q[6:0];
  assign bus.func3             = instr_q[14:12];
  assign bus.func7             = instr_q[31:25];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with RESET_PC = 0x100.
// Memory returns 0x00500093 at 0x100, 0x00A00113 at 0x104, and
// {addr[24:0], 7'h13} everywhere else.
module tb_instruction_fetch_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0100),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100)      return 32'h0050_0093;
    else if (a == 32'h104) return 32'h00A0_0113;
    else                   return {a[24:0], 7'h13};
  endfunction

  assign bus.imem_readdata = mem_word(bus.imem_address);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (bus.imem_read !== 1'b0) begin n_err++; $display("FAIL rst_read: got %b want 0", bus.imem_read); end
    n_cmp++; if (bus.instruction_if_id !== 32'h13) begin n_err++; $display("FAIL rst_instr: got %h want 00000013", bus.instruction_if_id); end
    n_cmp++; if (bus.valid_if_id !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.valid_if_id); end
    n_cmp++; if (bus.pc_if_id !== 32'h0) begin n_err++; $display("FAIL rst_pc_id: got %h want 00000000", bus.pc_if_id); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.imem_address !== 32'h100) begin n_err++; $display("FAIL rst_addr: got %h want 00000100", bus.imem_address); end
    n_cmp++; if (bus.imem_read !== 1'b1) begin n_err++; $display("FAIL rst_rel_read: got %b want 1", bus.imem_read); end
  endtask

  task automatic test_sequential;
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h100) begin n_err++; $display("FAIL seq0_pc: got %h want 00000100", bus.pc_if_id); end
    n_cmp++; if (bus.instruction_if_id !== 32'h0050_0093) begin n_err++; $display("FAIL seq0_instr: got %h want 00500093", bus.instruction_if_id); end
    n_cmp++; if (bus.opcode !== 7'b0010011) begin n_err++; $display("FAIL seq0_opcode: got %b want 0010011", bus.opcode); end
    n_cmp++; if (bus.func3 !== 3'b000) begin n_err++; $display("FAIL seq0_func3: got %b want 000", bus.func3); end
    n_cmp++; if (bus.func7 !== 7'b0000000) begin n_err++; $display("FAIL seq0_func7: got %b want 0000000", bus.func7); end
    n_cmp++; if (bus.valid_if_id !== 1'b1) begin n_err++; $display("FAIL seq0_valid: got %b want 1", bus.valid_if_id); end
    n_cmp++; if (bus.pc_plus4_if_id !== 32'h104) begin n_err++; $display("FAIL seq0_pc4: got %h want 00000104", bus.pc_plus4_if_id); end
    n_cmp++; if (bus.imem_address !== 32'h104) begin n_err++; $display("FAIL seq0_addr: got %h want 00000104", bus.imem_address); end
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h104) begin n_err++; $display("FAIL seq1_pc: got %h want 00000104", bus.pc_if_id); end
    n_cmp++; if (bus.instruction_if_id !== 32'h00A0_0113) begin n_err++; $display("FAIL seq1_instr: got %h want 00a00113", bus.instruction_if_id); end
    n_cmp++; if (bus.pc_plus4_if_id !== 32'h108) begin n_err++; $display("FAIL seq1_pc4: got %h want 00000108", bus.pc_plus4_if_id); end
    n_cmp++; if (bus.imem_address !== 32'h108) begin n_err++; $display("FAIL seq1_addr: got %h want 00000108", bus.imem_address); end
  endtask

  task automatic test_busywait;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h200;
    tick();
    bus.branch_taken = 1'b0;
    n_cmp++; if (bus.valid_if_id !== 1'b0) begin n_err++; $display("FAIL br_bubble: got %b want 0", bus.valid_if_id); end
    n_cmp++; if (bus.imem_address !== 32'h200) begin n_err++; $display("FAIL br_addr: got %h want 00000200", bus.imem_address); end
    bus.imem_busywait = 1'b1;
    #1;
    n_cmp++; if (bus.fetch_busy !== 1'b1) begin n_err++; $display("FAIL busy_flag: got %b want 1", bus.fetch_busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.valid_if_id !== 1'b0 || bus.instruction_if_id !== 32'h13) begin n_err++; $display("FAIL busy_bubble%0d: got v=%b i=%h want v=0 i=00000013", i, bus.valid_if_id, bus.instruction_if_id); end
      n_cmp++; if (bus.fetch_busy !== 1'b1) begin n_err++; $display("FAIL busy_flag%0d: got %b want 1", i, bus.fetch_busy); end
    end
    bus.imem_busywait = 1'b0;
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h200 || bus.instruction_if_id !== 32'h0001_0013 || bus.valid_if_id !== 1'b1) begin n_err++; $display("FAIL busy_release: got pc=%h i=%h v=%b want pc=00000200 i=00010013 v=1", bus.pc_if_id, bus.instruction_if_id, bus.valid_if_id); end
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h204 || bus.instruction_if_id !== 32'h0001_0213) begin n_err++; $display("FAIL busy_next: got pc=%h i=%h want pc=00000204 i=00010213", bus.pc_if_id, bus.instruction_if_id); end
  endtask

  task automatic test_stall_hold;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h2F8;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h2FC || bus.imem_address !== 32'h300) begin n_err++; $display("FAIL stall_pre: got pc=%h a=%h want pc=000002fc a=00000300", bus.pc_if_id, bus.imem_address); end
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.pc_if_id !== 32'h2FC || bus.instruction_if_id !== 32'h0001_7E13 || bus.valid_if_id !== 1'b1) begin n_err++; $display("FAIL stall_keep%0d: got pc=%h i=%h v=%b want pc=000002fc i=00017e13 v=1", i, bus.pc_if_id, bus.instruction_if_id, bus.valid_if_id); end
      n_cmp++; if (bus.imem_read !== 1'b0) begin n_err++; $display("FAIL hold_read%0d: got %b want 0", i, bus.imem_read); end
    end
    bus.stall = 1'b0;
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h300 || bus.instruction_if_id !== 32'h0001_8013 || bus.valid_if_id !== 1'b1) begin n_err++; $display("FAIL hold_release: got pc=%h i=%h v=%b want pc=00000300 i=00018013 v=1", bus.pc_if_id, bus.instruction_if_id, bus.valid_if_id); end
    n_cmp++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 32'h304) begin n_err++; $display("FAIL hold_refetch: got r=%b a=%h want r=1 a=00000304", bus.imem_read, bus.imem_address); end
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h304 || bus.instruction_if_id !== 32'h0001_8213) begin n_err++; $display("FAIL hold_next: got pc=%h i=%h want pc=00000304 i=00018213", bus.pc_if_id, bus.instruction_if_id); end
  endtask

  task automatic test_discard;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h50C;
    tick();
    bus.branch_taken = 1'b0;
    bus.imem_busywait = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h400;
    tick();
    bus.branch_taken = 1'b0;
    n_cmp++; if (bus.valid_if_id !== 1'b0 || bus.imem_address !== 32'h50C || bus.imem_read !== 1'b1) begin n_err++; $display("FAIL disc_enter: got v=%b a=%h r=%b want v=0 a=0000050c r=1", bus.valid_if_id, bus.imem_address, bus.imem_read); end
    tick();
    n_cmp++; if (bus.valid_if_id !== 1'b0 || bus.imem_address !== 32'h50C) begin n_err++; $display("FAIL disc_wait: got v=%b a=%h want v=0 a=0000050c", bus.valid_if_id, bus.imem_address); end
    bus.imem_busywait = 1'b0;
    tick();
    n_cmp++; if (bus.imem_address !== 32'h400 || bus.valid_if_id !== 1'b0 || bus.instruction_if_id !== 32'h13) begin n_err++; $display("FAIL disc_drop: got a=%h v=%b i=%h want a=00000400 v=0 i=00000013", bus.imem_address, bus.valid_if_id, bus.instruction_if_id); end
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h400 || bus.instruction_if_id !== 32'h0002_0013) begin n_err++; $display("FAIL disc_target: got pc=%h i=%h want pc=00000400 i=00020013", bus.pc_if_id, bus.instruction_if_id); end
  endtask

  task automatic test_double_redirect;
    bus.imem_busywait = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h600;
    tick();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h800;
    tick();
    bus.branch_taken = 1'b0;
    n_cmp++; if (bus.imem_address !== 32'h404) begin n_err++; $display("FAIL dbl_outstanding: got %h want 00000404", bus.imem_address); end
    bus.imem_busywait = 1'b0;
    tick();
    n_cmp++; if (bus.imem_address !== 32'h800) begin n_err++; $display("FAIL dbl_addr: got %h want 00000800", bus.imem_address); end
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h800 || bus.instruction_if_id !== 32'h0004_0013 || bus.valid_if_id !== 1'b1) begin n_err++; $display("FAIL dbl_target: got pc=%h i=%h v=%b want pc=00000800 i=00040013 v=1", bus.pc_if_id, bus.instruction_if_id, bus.valid_if_id); end
  endtask

  task automatic test_hold_branch;
    bus.stall = 1'b1;
    tick();
    n_cmp++; if (bus.imem_read !== 1'b0) begin n_err++; $display("FAIL hb_hold: got %b want 0", bus.imem_read); end
    bus.branch_taken = 1'b1; bus.branch_target = 32'h403;
    tick();
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    n_cmp++; if (bus.imem_address !== 32'h400 || bus.valid_if_id !== 1'b0 || bus.imem_read !== 1'b1) begin n_err++; $display("FAIL hb_redirect: got a=%h v=%b r=%b want a=00000400 v=0 r=1", bus.imem_address, bus.valid_if_id, bus.imem_read); end
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h400 || bus.instruction_if_id !== 32'h0002_0013 || bus.valid_if_id !== 1'b1) begin n_err++; $display("FAIL hb_target: got pc=%h i=%h v=%b want pc=00000400 i=00020013 v=1", bus.pc_if_id, bus.instruction_if_id, bus.valid_if_id); end
  endtask

  task automatic test_async_reset_wrap;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h1000;
    tick();
    bus.branch_taken = 1'b0;
    bus.imem_busywait = 1'b1;
    tick();
    n_cmp++; if (bus.imem_address !== 32'h1000 || bus.fetch_busy !== 1'b1) begin n_err++; $display("FAIL ar_busy: got a=%h b=%b want a=00001000 b=1", bus.imem_address, bus.fetch_busy); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.imem_read !== 1'b0 || bus.imem_address !== 32'h100) begin n_err++; $display("FAIL ar_async: got r=%b a=%h want r=0 a=00000100", bus.imem_read, bus.imem_address); end
    n_cmp++; if (bus.valid_if_id !== 1'b0 || bus.instruction_if_id !== 32'h13 || bus.pc_if_id !== 32'h0) begin n_err++; $display("FAIL ar_ifid: got v=%b i=%h pc=%h want v=0 i=00000013 pc=00000000", bus.valid_if_id, bus.instruction_if_id, bus.pc_if_id); end
    bus.imem_busywait = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.imem_address !== 32'h100 || bus.imem_read !== 1'b1) begin n_err++; $display("FAIL ar_release: got a=%h r=%b want a=00000100 r=1", bus.imem_address, bus.imem_read); end
    tick();
    n_cmp++; if (bus.pc_if_id !== 32'h100 || bus.instruction_if_id !== 32'h0050_0093) begin n_err++; $display("FAIL ar_first: got pc=%h i=%h want pc=00000100 i=00500093", bus.pc_if_id, bus.instruction_if_id); end
    bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFF;
    tick();
    bus.branch_taken = 1'b0;
    n_cmp++; if (bus.imem_address !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", bus.imem_address); end
    tick();
    n_cmp++; if (bus.imem_address !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %h want 00000000", bus.imem_address); end
    n_cmp++; if (bus.pc_if_id !== 32'hFFFF_FFFC || bus.pc_plus4_if_id !== 32'h0 || bus.instruction_if_id !== 32'hFFFF_FE13) begin n_err++; $display("FAIL wrap_ifid: got pc=%h p4=%h i=%h want pc=fffffffc p4=00000000 i=fffffe13", bus.pc_if_id, bus.pc_plus4_if_id, bus.instruction_if_id); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    bus.imem_busywait = 1'b0;
    test_reset();
    test_sequential();
    test_busywait();
    test_stall_hold();
    test_discard();
    test_double_redirect();
    test_hold_branch();
    test_async_reset_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
